reg_bank_arbiter: RTL and testbench

Shared register-bank controller for the SD host. Owns a bank of `NREG` 32-bit configuration/status registers and arbitrates single-word read/write access between two requesters: the CPU-side bus port (`cpu_*`) and the SD core engine (`core_*`). Conflicts are resolved round-robin. Each access is completed with a one-cycle acknowledge pulse.

---
 rtl/reg_bank_arbiter_if.sv | 17 +
 rtl/reg_bank_arbiter.sv | 108 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_arbiter_if.sv
// Single-word register access channel between one requester and the register-bank arbiter.
// The requester drives req/we/addr/be/wdata and receives a one-cycle ack with rdata.
interface reg_bank_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic               req;
  logic               we;
  logic [AW-1:0]      addr;
  logic [WIDTH/8-1:0] be;
  logic [WIDTH-1:0]   wdata;
  logic               ack;
  logic [WIDTH-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/reg_bank_arbiter.sv
// Shared SD-host register bank: round-robin arbitration between the CPU and core ports,
// one access at a time through IDLE -> ACCESS -> RESP, each completed by a one-cycle ack.
module reg_bank_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  reg_bank_arbiter_if.slave   cpu,
  reg_bank_arbiter_if.slave   core,
  output logic                busy
);

  localparam int NBYTE = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             grant_core;
  logic             last_grant_core;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [NBYTE-1:0] be_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] regs [NREG];
  logic             pick_core;

  // On a tie the port that did not win last time is picked.
  always_comb begin
    pick_core = core.req && (!cpu.req || !last_grant_core);
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking to avoid
  // read/write races between the arbiter fields and the register array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      cpu.ack         <= 1'b0;
      core.ack        <= 1'b0;
      cpu.rdata       <= '0;
      core.rdata      <= '0;
      last_grant_core <= 1'b1;
      grant_core      <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      be_q            <= '0;
      wdata_q         <= '0;
      // NOTE: the bank is architecturally zero after reset, so it is built from
      // resettable flops rather than a RAM macro; reset also blocks an in-flight write.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req || core.req) begin
            grant_core      <= pick_core;
            last_grant_core <= pick_core;
            if (pick_core) begin
              we_q    <= core.we;
              addr_q  <= core.addr;
              be_q    <= core.be;
              wdata_q <= core.wdata;
            end else begin
              we_q    <= cpu.we;
              addr_q  <= cpu.addr;
              be_q    <= cpu.be;
              wdata_q <= cpu.wdata;
            end
            busy  <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            for (int b = 0; b < NBYTE; b++) begin
              if (be_q[b]) begin
                regs[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
              end
            end
          end else if (grant_core) begin
            core.rdata <= regs[addr_q];
          end else begin
            cpu.rdata <= regs[addr_q];
          end
          cpu.ack  <= !grant_core;
          core.ack <= grant_core;
          state    <= RESP;
        end
        RESP: begin
          cpu.ack  <= 1'b0;
          core.ack <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          cpu.ack  <= 1'b0;
          core.ack <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model of the register bank and round-robin rule.
module tb_reg_bank_arbiter;

  logic clk;
  logic reset;
  logic busy;

  reg_bank_arbiter_if #(.WIDTH(32), .AW(4)) cpu_bus ();
  reg_bank_arbiter_if #(.WIDTH(32), .AW(4)) core_bus ();

  reg_bank_arbiter #(.WIDTH(32), .NREG(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu_bus),
    .core  (core_bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference model.
  logic [31:0] m_regs [16];
  logic        m_last_core;
  logic [31:0] m_rd_cpu;
  logic [31:0] m_rd_core;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_last_core = 1'b1;
    m_rd_cpu    = 32'h0;
    m_rd_core   = 32'h0;
  endtask

  task automatic model_serve(input bit is_core, input bit we, input logic [3:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) m_regs[addr][i*8 +: 8] = wd[i*8 +: 8];
      end
    end else begin
      if (is_core) m_rd_core = m_regs[addr];
      else         m_rd_cpu  = m_regs[addr];
    end
    m_last_core = is_core;
  endtask

  task automatic idle_inputs();
    cpu_bus.req   = 1'b0; cpu_bus.we  = 1'b0; cpu_bus.addr  = 4'h0;
    cpu_bus.be    = 4'h0; cpu_bus.wdata = 32'h0;
    core_bus.req  = 1'b0; core_bus.we = 1'b0; core_bus.addr = 4'h0;
    core_bus.be   = 4'h0; core_bus.wdata = 32'h0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // Issues one request on each enabled port in the same cycle and scores ack timing,
  // busy, and read data. Each port drops req in the cycle after it sees its ack.
  task automatic run_pair(input string tag,
                          input bit c_en, input bit c_we, input logic [3:0] c_addr,
                          input logic [3:0] c_be, input logic [31:0] c_wd,
                          input bit k_en, input bit k_we, input logic [3:0] k_addr,
                          input logic [3:0] k_be, input logic [31:0] k_wd,
                          output logic [31:0] c_rd, output logic [31:0] k_rd);
    bit          core_first;
    int          c_cyc, k_cyc;
    logic [31:0] exp_c_rd, exp_k_rd;
    logic [15:0] cm, km, bm, exp_cm, exp_km, exp_bm;
    int          n_served;

    core_first = (c_en && k_en) ? !m_last_core : k_en;
    c_cyc = (c_en && k_en && core_first) ? 5 : 2;
    k_cyc = (c_en && k_en && !core_first) ? 5 : 2;
    if (core_first) begin
      if (k_en) model_serve(1'b1, k_we, k_addr, k_be, k_wd);
      if (c_en) model_serve(1'b0, c_we, c_addr, c_be, c_wd);
    end else begin
      if (c_en) model_serve(1'b0, c_we, c_addr, c_be, c_wd);
      if (k_en) model_serve(1'b1, k_we, k_addr, k_be, k_wd);
    end
    exp_c_rd = m_rd_cpu;
    exp_k_rd = m_rd_core;
    n_served = int'(c_en) + int'(k_en);
    exp_cm = c_en ? (16'h1 << c_cyc) : 16'h0;
    exp_km = k_en ? (16'h1 << k_cyc) : 16'h0;
    exp_bm = (n_served == 2) ? 16'h0036 : 16'h0006;

    @(posedge clk); #1;
    cpu_bus.req  = c_en;  cpu_bus.we  = c_we;  cpu_bus.addr  = c_addr;
    cpu_bus.be   = c_be;  cpu_bus.wdata = c_wd;
    core_bus.req = k_en;  core_bus.we = k_we;  core_bus.addr = k_addr;
    core_bus.be  = k_be;  core_bus.wdata = k_wd;
    cm = '0; km = '0; bm = '0;
    c_rd = cpu_bus.rdata; k_rd = core_bus.rdata;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      cm[cyc] = cpu_bus.ack;
      km[cyc] = core_bus.ack;
      bm[cyc] = busy;
      if (cpu_bus.ack)  c_rd = cpu_bus.rdata;
      if (core_bus.ack) k_rd = core_bus.rdata;
      @(posedge clk); #1;
      if (cm[cyc]) begin cpu_bus.req  = 1'b0; cpu_bus.wdata  = $urandom; end
      if (km[cyc]) begin core_bus.req = 1'b0; core_bus.wdata = $urandom; end
    end

    n_checks++;
    if (cm !== exp_cm) begin
      n_fail++; $display("FAIL %s cpu_ack cycles: got %b expected %b", tag, cm, exp_cm);
    end
    n_checks++;
    if (km !== exp_km) begin
      n_fail++; $display("FAIL %s core_ack cycles: got %b expected %b", tag, km, exp_km);
    end
    n_checks++;
    if (bm !== exp_bm) begin
      n_fail++; $display("FAIL %s busy cycles: got %b expected %b", tag, bm, exp_bm);
    end
    n_checks++;
    if (cpu_bus.rdata !== exp_c_rd) begin
      n_fail++; $display("FAIL %s cpu_rdata: got %h expected %h", tag, cpu_bus.rdata, exp_c_rd);
    end
    n_checks++;
    if (core_bus.rdata !== exp_k_rd) begin
      n_fail++; $display("FAIL %s core_rdata: got %h expected %h", tag, core_bus.rdata, exp_k_rd);
    end
    if (c_en && !c_we) begin
      n_checks++;
      if (c_rd !== exp_c_rd) begin
        n_fail++; $display("FAIL %s cpu_rdata at ack: got %h expected %h", tag, c_rd, exp_c_rd);
      end
    end
    if (k_en && !k_we) begin
      n_checks++;
      if (k_rd !== exp_k_rd) begin
        n_fail++; $display("FAIL %s core_rdata at ack: got %h expected %h", tag, k_rd, exp_k_rd);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_bus.ack, core_bus.ack, busy} !== 3'b000 ||
          cpu_bus.rdata !== 32'h0 || core_bus.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: ack/ack/busy=%b cpu_rdata=%h core_rdata=%h expected all 0",
                 cyc, {cpu_bus.ack, core_bus.ack, busy}, cpu_bus.rdata, core_bus.rdata);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    logic [31:0] c_rd, k_rd;
    run_pair("cpu_write", 1, 1, 4'd3, 4'hF, 32'hDEADBEEF, 0, 0, 4'd0, 4'h0, 32'h0, c_rd, k_rd);
    run_pair("cpu_read", 1, 0, 4'd3, 4'h0, 32'h0, 0, 0, 4'd0, 4'h0, 32'h0, c_rd, k_rd);
    n_checks++;
    if (c_rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL cpu_read_const: got %h expected deadbeef", c_rd);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] c_rd, k_rd;
    run_pair("be_full", 0, 0, 4'd0, 4'h0, 32'h0, 1, 1, 4'd5, 4'hF, 32'hFFFFFFFF, c_rd, k_rd);
    run_pair("be_part", 0, 0, 4'd0, 4'h0, 32'h0, 1, 1, 4'd5, 4'h5, 32'h12345678, c_rd, k_rd);
    run_pair("be_zero", 0, 0, 4'd0, 4'h0, 32'h0, 1, 1, 4'd5, 4'h0, 32'h00000000, c_rd, k_rd);
    run_pair("be_read", 0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 4'd5, 4'h0, 32'h0, c_rd, k_rd);
    n_checks++;
    if (k_rd !== 32'hFF34FF78) begin
      n_fail++; $display("FAIL be_read_const: got %h expected ff34ff78", k_rd);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] c_rd, k_rd;
    apply_reset();
    run_pair("tie_1", 1, 1, 4'd1, 4'hF, 32'hA, 1, 1, 4'd1, 4'hF, 32'hB, c_rd, k_rd);
    run_pair("tie_1_chk", 1, 0, 4'd1, 4'h0, 32'h0, 0, 0, 4'd0, 4'h0, 32'h0, c_rd, k_rd);
    n_checks++;
    if (c_rd !== 32'hB) begin
      n_fail++; $display("FAIL tie_1_final: got %h expected 0000000b", c_rd);
    end
    run_pair("tie_2", 1, 1, 4'd1, 4'hF, 32'hC, 1, 1, 4'd1, 4'hF, 32'hD, c_rd, k_rd);
    run_pair("tie_2_chk", 0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 4'd1, 4'h0, 32'h0, c_rd, k_rd);
    n_checks++;
    if (k_rd !== 32'hC) begin
      n_fail++; $display("FAIL tie_2_final: got %h expected 0000000c", k_rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] c_rd, k_rd;
    logic        saw_ack;
    @(posedge clk); #1;
    core_bus.req = 1'b1; core_bus.we = 1'b1; core_bus.addr = 4'd7;
    core_bus.be  = 4'hF; core_bus.wdata = 32'h55;
    @(posedge clk); #1;
    reset = 1'b0;
    core_bus.req = 1'b0;
    saw_ack = 1'b0;
    @(negedge clk);
    saw_ack |= core_bus.ack;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cpu_bus.ack !== 1'b0 || core_bus.ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid busy/acks: got %b%b%b expected 000",
                         busy, cpu_bus.ack, core_bus.ack);
    end
    @(posedge clk); #1 reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      saw_ack |= core_bus.ack;
    end
    n_checks++;
    if (saw_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid core_ack: got pulse expected none");
    end
    run_pair("reset_mid_read", 0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 4'd7, 4'h0, 32'h0, c_rd, k_rd);
    n_checks++;
    if (k_rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_reg7: got %h expected 00000000", k_rd);
    end
  endtask

  // CPU keeps req high for two cycles past its ack; optionally the core joins meanwhile.
  task automatic test_held_request(input bit with_core);
    logic [15:0] cm, km, exp_cm, exp_km;
    logic [31:0] exp_c_rd, exp_k_rd;
    logic [3:0]  c_addr, k_addr;
    c_addr = 4'($urandom_range(0, 15));
    k_addr = 4'($urandom_range(0, 15));
    model_serve(1'b0, 1'b0, c_addr, 4'h0, 32'h0);
    if (with_core) begin
      model_serve(1'b1, 1'b0, k_addr, 4'h0, 32'h0);
      exp_cm = 16'h0004; exp_km = 16'h0020;
    end else begin
      model_serve(1'b0, 1'b0, c_addr, 4'h0, 32'h0);
      exp_cm = 16'h0024; exp_km = 16'h0000;
    end
    exp_c_rd = m_rd_cpu;
    exp_k_rd = m_rd_core;

    @(posedge clk); #1;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = c_addr;
    core_bus.we = 1'b0; core_bus.addr = k_addr;
    cm = '0; km = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      cm[cyc] = cpu_bus.ack;
      km[cyc] = core_bus.ack;
      @(posedge clk); #1;
      if (cyc == 4) cpu_bus.req = 1'b0;
      if (with_core && cyc == 0) core_bus.req = 1'b1;
      if (km[cyc]) core_bus.req = 1'b0;
    end
    n_checks++;
    if (cm !== exp_cm) begin
      n_fail++; $display("FAIL held_%0d cpu_ack cycles: got %b expected %b", with_core, cm, exp_cm);
    end
    n_checks++;
    if (km !== exp_km) begin
      n_fail++; $display("FAIL held_%0d core_ack cycles: got %b expected %b", with_core, km, exp_km);
    end
    n_checks++;
    if (cpu_bus.rdata !== exp_c_rd || core_bus.rdata !== exp_k_rd) begin
      n_fail++; $display("FAIL held_%0d rdata: got %h/%h expected %h/%h", with_core,
                         cpu_bus.rdata, core_bus.rdata, exp_c_rd, exp_k_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] c_rd, k_rd;
    bit          c_en, k_en;
    for (int i = 0; i < 24; i++) begin
      c_en = 1'($urandom_range(0, 1));
      k_en = 1'($urandom_range(0, 1));
      if (!c_en && !k_en) c_en = 1'b1;
      run_pair($sformatf("rand_%0d", i),
               c_en, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), $urandom,
               k_en, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), $urandom,
               c_rd, k_rd);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    test_reset();
    test_cpu_write_read();
    test_byte_enables();
    test_simultaneous();
    test_reset_mid_op();
    test_held_request(1'b0);
    test_held_request(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
